// File: rtl/uart_tx_pkg.sv
// Shared types and mode decoding for the UART transmit frame sequencer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_t;

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_EVEN  = 2'b01;
    localparam logic [1:0] MODE_ODD   = 2'b10;
    localparam logic [1:0] MODE_NONE2 = 2'b11;

    function automatic parity_t decode_parity(input logic [1:0] mode);
        parity_t p;
        case (mode)
            MODE_EVEN: p = EVEN;
            MODE_ODD:  p = ODD;
            default:   p = NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Free-running bit-period counter; wraps at CLKS_PER_BIT-1 and restarts on clear.
module uart_tx_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic                            clear,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count,
    output logic                            bit_end
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            count_q <= '0;
        end else if (clear || bit_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count   = count_q;
    assign bit_end = (count_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit frame engine: start, LSB-first data, optional parity, stop bits.
// Every output is a register fed from the current state, so the pin lags the FSM by one clock.
module uart_tx_frame_sequencer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_TX_DV,
    input  logic [DATA_BITS-1:0] i_TX_Data,
    input  logic [1:0]           i_Parity_Mode,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Active,
    output logic                 o_TX_Done,
    output logic [((DATA_BITS > 1) ? $clog2(DATA_BITS) : 1)-1:0] o_Bit_Index,
    output logic                 o_Bit_Index_Enable
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    parity_t              parity_q, parity_d;

    logic clear;
    logic bit_end;

    logic serial_d;
    logic active_d;
    logic done_d;
    logic enable_d;

    uart_tx_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .clear  (clear),
        .count  (),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        data_d   = data_q;
        parity_d = parity_q;

        unique case (state_q)
            IDLE: begin
                if (i_TX_DV) begin
                    data_d   = i_TX_Data;
                    parity_d = decode_parity(i_Parity_Mode);
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d   = '0;
                        state_d = (parity_q != NONE) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == LAST_STOP) begin
                        stop_d  = '0;
                        state_d = CLEANUP;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Restarting the bit period on every transition keeps each bit exactly CLKS_PER_BIT long.
    assign clear = (state_d != state_q);

    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        enable_d = 1'b0;

        unique case (state_q)
            START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            DATA: begin
                serial_d = data_q[idx_q];
                active_d = 1'b1;
                enable_d = bit_end;
            end
            PARITY: begin
                serial_d = (parity_q == ODD) ? ~(^data_q) : ^data_q;
                active_d = 1'b1;
            end
            STOP: begin
                active_d = 1'b1;
            end
            CLEANUP: begin
                done_d = 1'b1;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q            <= IDLE;
            idx_q              <= '0;
            stop_q             <= '0;
            data_q             <= '0;
            parity_q           <= NONE;
            o_TX_Serial        <= 1'b1;
            o_TX_Active        <= 1'b0;
            o_TX_Done          <= 1'b0;
            o_Bit_Index        <= '0;
            o_Bit_Index_Enable <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            stop_q             <= stop_d;
            data_q             <= data_d;
            parity_q           <= parity_d;
            o_TX_Serial        <= serial_d;
            o_TX_Active        <= active_d;
            o_TX_Done          <= done_d;
            o_Bit_Index        <= idx_q;
            o_Bit_Index_Enable <= enable_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Self-checking bench: two configurations (8/4/1 and 5/3/2) compared cycle by cycle against
// a frame model built from the bit list of each request.
module tb_uart_tx_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       dv_a = 1'b0;
    logic [7:0] data_a = '0;
    logic [1:0] mode_a = '0;
    logic       serial_a, active_a, done_a, en_a;
    logic [2:0] idx_a;

    logic       dv_b = 1'b0;
    logic [4:0] data_b = '0;
    logic [1:0] mode_b = '0;
    logic       serial_b, active_b, done_b, en_b;
    logic [2:0] idx_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame_sequencer #(
        .CLKS_PER_BIT(4),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) u_dut_a (
        .i_Clock           (clk),
        .i_Reset           (rst),
        .i_TX_DV           (dv_a),
        .i_TX_Data         (data_a),
        .i_Parity_Mode     (mode_a),
        .o_TX_Serial       (serial_a),
        .o_TX_Active       (active_a),
        .o_TX_Done         (done_a),
        .o_Bit_Index       (idx_a),
        .o_Bit_Index_Enable(en_a)
    );

    uart_tx_frame_sequencer #(
        .CLKS_PER_BIT(3),
        .DATA_BITS   (5),
        .STOP_BITS   (2)
    ) u_dut_b (
        .i_Clock           (clk),
        .i_Reset           (rst),
        .i_TX_DV           (dv_b),
        .i_TX_Data         (data_b),
        .i_Parity_Mode     (mode_b),
        .o_TX_Serial       (serial_b),
        .o_TX_Active       (active_b),
        .o_TX_Done         (done_b),
        .o_Bit_Index       (idx_b),
        .o_Bit_Index_Enable(en_b)
    );

    task automatic chk(input string tag, input int cyc, input logic [8:0] obs,
                       input logic [8:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic get_outs(input int cfg, output logic ser, output logic act,
                            output logic dn, output logic en, output logic [2:0] ix);
        if (cfg == 0) begin
            ser = serial_a; act = active_a; dn = done_a; en = en_a; ix = idx_a;
        end else begin
            ser = serial_b; act = active_b; dn = done_b; en = en_b; ix = idx_b;
        end
    endtask

    task automatic drive(input int cfg, input logic dv, input logic [8:0] d,
                         input logic [1:0] m);
        if (cfg == 0) begin
            dv_a = dv; data_a = d[7:0]; mode_a = m;
        end else begin
            dv_b = dv; data_b = d[4:0]; mode_b = m;
        end
    endtask

    task automatic set_dv(input int cfg, input logic dv);
        if (cfg == 0) dv_a = dv;
        else          dv_b = dv;
    endtask

    task automatic chk_idle(input int cfg, input string tag, input int cyc);
        logic ser, act, dn, en;
        logic [2:0] ix;
        get_outs(cfg, ser, act, dn, en, ix);
        chk({tag, "_serial"}, cyc, 9'(ser), 9'd1);
        chk({tag, "_active"}, cyc, 9'(act), 9'd0);
        chk({tag, "_done"},   cyc, 9'(dn),  9'd0);
        chk({tag, "_enable"}, cyc, 9'(en),  9'd0);
        chk({tag, "_index"},  cyc, 9'(ix),  9'd0);
    endtask

    // Called #1 after an edge with the DUT idle; the following edge accepts the request.
    task automatic run_frame(input int cfg, input logic [8:0] d, input logic [1:0] m,
                             input bit hold, input int reset_at, input bit scramble);
        int db, cpb, sb, t, b;
        int bits[$];
        bit par_en;
        logic ser, act, dn, en;
        logic [2:0] ix;
        logic e_ser, e_act, e_dn, e_en;
        int e_ix;

        db  = (cfg == 0) ? 8 : 5;
        cpb = (cfg == 0) ? 4 : 3;
        sb  = (cfg == 0) ? 1 : 2;
        par_en = (m == 2'b01) || (m == 2'b10);

        bits.delete();
        bits.push_back(0);
        for (int i = 0; i < db; i++) bits.push_back(int'(d[i]));
        if (par_en) begin
            int ones = 0;
            for (int i = 0; i < db; i++) ones += int'(d[i]);
            bits.push_back((m == 2'b01) ? (ones % 2) : (1 - ones % 2));
        end
        for (int i = 0; i < sb; i++) bits.push_back(1);
        t = bits.size() * cpb;

        drive(cfg, 1'b1, d, m);
        @(posedge clk);
        #1;
        chk_idle(cfg, "accept", 0);
        if (!hold) set_dv(cfg, 1'b0);

        for (int c = 1; c <= t + 1; c++) begin
            if (scramble) drive(cfg, hold, 9'($urandom), 2'($urandom));
            @(posedge clk);
            #1;
            if (c <= t) begin
                b     = (c - 1) / cpb;
                e_ser = bits[b][0];
                e_act = 1'b1;
                e_dn  = 1'b0;
                e_en  = (b >= 1) && (b <= db) && (c % cpb == 0);
                e_ix  = ((b >= 1) && (b <= db)) ? b - 1 : 0;
            end else begin
                e_ser = 1'b1;
                e_act = 1'b0;
                e_dn  = 1'b1;
                e_en  = 1'b0;
                e_ix  = 0;
            end
            get_outs(cfg, ser, act, dn, en, ix);
            chk("serial", c, 9'(ser), 9'(e_ser));
            chk("active", c, 9'(act), 9'(e_act));
            chk("done",   c, 9'(dn),  9'(e_dn));
            chk("enable", c, 9'(en),  9'(e_en));
            chk("index",  c, 9'(ix),  9'(e_ix));

            if (c == reset_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk_idle(cfg, "abort", c + 1);
                for (int k = 2; k <= 4; k++) begin
                    @(posedge clk);
                    #1;
                    chk_idle(cfg, "post_abort", c + k);
                end
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle(0, "reset_a", 0);
        chk_idle(1, "reset_b", 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_idle(0, "after_reset_a", 0);

        run_frame(0, 9'h05A, 2'b00, 1'b0, -1, 1'b0);
        run_frame(0, 9'h05A, 2'b01, 1'b0, -1, 1'b0);
        run_frame(0, 9'h05A, 2'b10, 1'b0, -1, 1'b0);
        run_frame(0, 9'h05A, 2'b11, 1'b0, -1, 1'b0);

        run_frame(1, 9'h013, 2'b00, 1'b0, -1, 1'b0);
        run_frame(1, 9'h013, 2'b10, 1'b0, -1, 1'b0);

        // DV held high across two frames; the second is accepted after one idle cycle.
        run_frame(0, 9'h0C3, 2'b00, 1'b1, -1, 1'b0);
        run_frame(0, 9'h03C, 2'b01, 1'b0, -1, 1'b0);
        run_frame(1, 9'h01B, 2'b01, 1'b1, -1, 1'b0);
        run_frame(1, 9'h004, 2'b00, 1'b0, -1, 1'b0);

        run_frame(0, 9'h0A5, 2'b01, 1'b0, 10, 1'b0);
        run_frame(0, 9'h0A5, 2'b01, 1'b0, -1, 1'b0);
        run_frame(1, 9'h015, 2'b10, 1'b0, 7, 1'b0);
        run_frame(1, 9'h00A, 2'b01, 1'b0, -1, 1'b0);

        run_frame(0, 9'h0E1, 2'b10, 1'b0, -1, 1'b1);
        run_frame(1, 9'h01E, 2'b01, 1'b0, -1, 1'b1);

        for (int n = 0; n < 8; n++) begin
            run_frame(int'($urandom_range(0, 1)), 9'($urandom), 2'($urandom), 1'b0, -1,
                      1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_sequencer.md
Name: uart_tx_frame_sequencer

Overview:
Parametrised UART transmit frame engine. Serialises one word per request as start bit, DATA_BITS data bits LSB-first, optional parity bit, and STOP_BITS stop bits, each bit CLKS_PER_BIT clocks long. It owns the baud counter, the bit index, the frame FSM and the serial line. It generalises the fixed 8-bit/no-parity/1-stop TX path and sits between the SPI-or-UART config mux and the TX pin.

Parameters:
CLKS_PER_BIT, 5208, clocks per serial bit; legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
i_Clock  in  1  system clock; all state changes on the rising edge.
i_Reset  in  1  synchronous reset, active-high.
i_TX_DV  in  1  send request; sampled only in IDLE.
i_TX_Data  in  DATA_BITS  word to send; latched when the request is accepted.
i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none; latched with the data.
o_TX_Serial  out  1  serial line; idle level is 1.
o_TX_Active  out  1  high while a frame is on the line.
o_TX_Done  out  1  one-cycle pulse after the last stop bit.
o_Bit_Index  out  max(1,$clog2(DATA_BITS))  index of the data bit being sent.
o_Bit_Index_Enable  out  1  one-cycle pulse on the last clock of each data bit.

Behaviour:
- Reset: i_Reset=1 at an edge forces IDLE, baud counter 0, bit index 0, stop counter 0 and data/parity registers 0. Outputs after reset: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_Bit_Index=0, o_Bit_Index_Enable=0. Reset mid-frame aborts the frame at that edge with no o_TX_Done. Reset has priority over all other inputs.
- All outputs are registered and reflect the current state.
- Baud counter: runs 0..CLKS_PER_BIT-1 and wraps to 0. "bit_end" means counter = CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT). The counter is cleared on every state transition.
- IDLE: line=1, Active=0. If i_TX_DV=1 at an edge, latch data and mode and go to START.
- START: line=0, Active=1. On bit_end go to DATA with index 0.
- DATA: line=data[index].
  - On bit_end: Enable=1 for that cycle.
  - If index < DATA_BITS-1, increment index.
  - Otherwise clear index to 0 and go to PARITY if mode is 01 or 10, else go to STOP.
  - The index never exceeds DATA_BITS-1, including for non-power-of-two DATA_BITS.
- PARITY: line = XOR of data (even) or its inverse (odd). On bit_end go to STOP.
- STOP: line=1. The stop counter counts bit_ends. After STOP_BITS bit_ends go to CLEANUP.
- CLEANUP: one cycle. line=1, Active=0, Done=1. Then go to IDLE.
- Latency: if the request is accepted at edge k, the line falls after edge k. o_TX_Done is high in the cycle that starts at edge k + (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT + 1, where P=1 if parity is enabled, else 0.
- Requests outside IDLE, including in CLEANUP, are ignored and not queued. Back-to-back frames are therefore separated by one idle-level cycle.
- Changes to i_TX_Data or i_Parity_Mode mid-frame have no effect.

Decomposition:
- uart_tx_pkg holds:
  - state_t, extended with PARITY: IDLE, START, DATA, PARITY, STOP, CLEANUP; enum 3 bits.
  - parity_t: NONE, EVEN, ODD.
  - Mode-decode constants.
- Sub-module uart_tx_baud_counter, parametrised by CLKS_PER_BIT. Inputs i_Clock, i_Reset and clear. Outputs count and bit_end.

Test Plan:
- Parameters 8 data bits, CLKS_PER_BIT=4, 1 stop bit, mode 00. Send 0x5A. Line must be 0 | 0,1,0,1,1,0,1,0 | 1, each bit 4 cycles. Done in cycle 41 after the accept edge. Enable pulses 8 times with index 0..7.
- Same parameters, mode 01 then mode 10, data 0x5A. Parity bit must be 0 (even) then 1 (odd). Frame is 44 cycles; Done in cycle 45.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=3. Send 0x13. Index must run 0..4 and return to 0. Two stop bits of 3 cycles each. Frame is 24 cycles.
- Hold i_TX_DV=1 continuously over 2 frames. Second frame's start bit must begin exactly 1 cycle after the Done cycle. DV during the frame must be ignored.
- Assert reset at cycle 10 of a frame. Line=1 and Active=0 from the next edge. No Done pulse. A new request 2 cycles later must produce a full frame.
- Change i_TX_Data and i_Parity_Mode mid-frame. The transmitted bits must still equal the latched values.
